aes_inv_round_mix: RTL

Iterative decryption-side round back-end for the AES core. It computes AddRoundKey followed by InvMixColumns, i.e. data_out = InvMixColumns(state ^ round_key), one column per clock. This is the inverse counterpart of the encryption MixColumns/AddRoundKey XOR network. It sits after the InvShiftRows/InvSubBytes stage in the decryption datapath and exchanges 128-bit blocks with its neighbours over valid/ready handshakes.

---
 rtl/aes_inv_round_mix_if.sv | 19 +
 rtl/aes_inv_round_mix.sv | 75 +++++++
 2 files changed

// File: rtl/aes_inv_round_mix_if.sv
// aes_inv_round_mix_if: block handshake bundle between the decryption round stages and the mix back-end
interface aes_inv_round_mix_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] state;
  logic [127:0] round_key;
  logic last_round;
  logic out_valid;
  logic out_ready;
  logic [127:0] data_out;
  modport master (
    output in_valid, state, round_key, last_round, out_ready,
    input in_ready, out_valid, data_out
  );
  modport slave (
    input in_valid, state, round_key, last_round, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/aes_inv_round_mix.sv
// aes_inv_round_mix: AddRoundKey then InvMixColumns, one column per clock on a shared column datapath
module aes_inv_round_mix (
  input logic clk,
  input logic rst,
  aes_inv_round_mix_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_t;
  fsm_t fsm;
  logic [1:0] col;
  logic [127:0] work;
  logic [6:0] sel;
  logic [31:0] a, b;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction
  // column 0 sits in the top 32 bits, so the slice base is (3-col)*32
  assign sel = {~col, 5'b0};
  assign a = work[sel +: 32];
  always_comb begin
    b[31:24] = me(a[31:24]) ^ mb(a[23:16]) ^ md(a[15:8]) ^ m9(a[7:0]);
    b[23:16] = m9(a[31:24]) ^ me(a[23:16]) ^ mb(a[15:8]) ^ md(a[7:0]);
    b[15:8]  = md(a[31:24]) ^ m9(a[23:16]) ^ me(a[15:8]) ^ mb(a[7:0]);
    b[7:0]   = mb(a[31:24]) ^ md(a[23:16]) ^ m9(a[15:8]) ^ me(a[7:0]);
  end
  assign bus.data_out = work;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      col <= 2'd0;
      work <= 128'h0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (bus.in_valid) begin
          work <= bus.state ^ bus.round_key;
          col <= 2'd0;
          bus.in_ready <= 1'b0;
          bus.out_valid <= bus.last_round;
          fsm <= bus.last_round ? DONE : CALC;
        end
        CALC: begin
          work[sel +: 32] <= b;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            fsm <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          fsm <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: begin
          fsm <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
